// File: rtl/data_mem_unit_pkg.sv
// rtl/data_mem_unit_pkg.sv - shared types and defaults for the MEM-stage data memory
package data_mem_unit_pkg;

    localparam int DMEM_LATENCY_DEFAULT = 2;
    localparam int DMEM_DATA_W          = 32;
    localparam int DMEM_DEPTH_WORDS     = 256;
    localparam int DMEM_IDX_W           = $clog2(DMEM_DEPTH_WORDS);

    typedef enum logic {
        DMEM_IDLE,
        DMEM_BUSY
    } dmem_state_t;

    // Request capture register; field widths follow the package defaults.
    typedef struct packed {
        logic                   op_read;
        logic                   op_write;
        logic [DMEM_IDX_W-1:0]  index;
        logic [DMEM_DATA_W-1:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word array, synchronous write, combinational read
module dmem_array #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_unit.sv
// rtl/data_mem_unit.sv - multi-cycle data memory responding to memRead/memWrite with stall
module data_mem_unit
    import data_mem_unit_pkg::*;
#(
    parameter int DATA_W      = DMEM_DATA_W,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter int LATENCY     = DMEM_LATENCY_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    dmem_state_t       state_q;
    logic [CNT_W-1:0]  cnt_q;
    dmem_req_t         req_q, req_d;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q, err_q;

    logic              req, legal, accept, done, load_due, arr_we;
    logic [DATA_W-1:0] arr_rdata;
    logic              unused_addr;

    assign req    = mem_read | mem_write;
    assign legal  = (addr[1:0] == 2'b00) && !(mem_read && mem_write);
    assign accept = (state_q == DMEM_IDLE) && req && legal;
    assign done   = (state_q == DMEM_BUSY) && (cnt_q == '0);
    assign stall  = rst_n && (accept || ((state_q == DMEM_BUSY) && (cnt_q != '0)));
    assign arr_we = done && req_q.op_write;

    // Load data is registered on the edge that enters the completion cycle,
    // so with LATENCY=1 that edge is the accepting one.
    assign load_due = (LATENCY == 1) ? (accept && mem_read)
                                     : ((state_q == DMEM_BUSY) && (cnt_q == CNT_ONE) && req_q.op_read);

    assign unused_addr = ^addr[ADDR_W-1:IDX_W+2];

    always_comb begin
        req_d = req_q;
        if (accept) begin
            req_d.op_read  = mem_read;
            req_d.op_write = mem_write;
            req_d.index    = addr[IDX_W+1:2];
            req_d.wdata    = wdata;
        end
    end

    dmem_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .addr_i  (req_d.index),
        .wdata_i (req_q.wdata),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= DMEM_IDLE;
            cnt_q    <= '0;
            req_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            req_q    <= req_d;
            rvalid_q <= load_due;
            err_q    <= (state_q == DMEM_IDLE) && req && !legal;
            if (load_due) begin
                rdata_q <= arr_rdata;
            end
            case (state_q)
                DMEM_IDLE: begin
                    if (accept) begin
                        state_q <= DMEM_BUSY;
                        cnt_q   <= CNT_INIT;
                    end
                end
                DMEM_BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= DMEM_IDLE;
                    end
                end
            endcase
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rvalid_q;
    assign err         = err_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// tb/tb_data_mem_unit.sv - scoreboard bench for data_mem_unit at LATENCY 2 and 1
module tb_data_mem_unit;

    logic        clk;
    logic        rst_n;
    logic        rd_s   [2];
    logic        wr_s   [2];
    logic [31:0] a_s    [2];
    logic [31:0] d_s    [2];
    logic        stall_s[2];
    logic        v_s    [2];
    logic        err_s  [2];
    logic [31:0] rdata_s[2];

    int checks   = 0;
    int failures = 0;

    logic [31:0] sbq0[$];
    logic [31:0] sbq1[$];
    logic [31:0] mdl [2][256];

    data_mem_unit #(.LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(rd_s[0]), .mem_write(wr_s[0]),
        .addr(a_s[0]), .wdata(d_s[0]), .stall(stall_s[0]), .rdata(rdata_s[0]),
        .rdata_valid(v_s[0]), .err(err_s[0])
    );

    data_mem_unit #(.LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .mem_read(rd_s[1]), .mem_write(wr_s[1]),
        .addr(a_s[1]), .wdata(d_s[1]), .stall(stall_s[1]), .rdata(rdata_s[1]),
        .rdata_valid(v_s[1]), .err(err_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic monitor_unit(input int u);
        logic [31:0] exp_d;
        bit          empty;
        if (v_s[u]) begin
            checks++;
            empty = (u == 0) ? (sbq0.size() == 0) : (sbq1.size() == 0);
            if (empty) begin
                failures++;
                $display("FAIL sb_unexpected_valid u%0d rdata=%h expected no pulse", u, rdata_s[u]);
            end else begin
                exp_d = (u == 0) ? sbq0.pop_front() : sbq1.pop_front();
                if (rdata_s[u] !== exp_d) begin
                    failures++;
                    $display("FAIL sb_rdata u%0d got=%h exp=%h", u, rdata_s[u], exp_d);
                end
            end
            checks++;
            if (err_s[u] !== 1'b0) begin
                failures++;
                $display("FAIL err_with_valid u%0d err=%b exp=0", u, err_s[u]);
            end
        end
    endtask

    always @(negedge clk) if (rst_n) monitor_unit(0);
    always @(negedge clk) if (rst_n) monitor_unit(1);

    task automatic clear_inputs(input int u);
        rd_s[u] = 1'b0;
        wr_s[u] = 1'b0;
        a_s[u]  = '0;
        d_s[u]  = '0;
    endtask

    task automatic issue(input int u, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        int          lat, n_stall, v_cyc, exp_stall, exp_v;
        logic        e1, e2;
        bit          legal;
        logic [31:0] rd_before;
        lat   = (u == 0) ? 2 : 1;
        legal = (a[1:0] == 2'b00) && !(rd && wr);
        if (legal && rd) begin
            if (u == 0) sbq0.push_back(mdl[u][a[9:2]]);
            else        sbq1.push_back(mdl[u][a[9:2]]);
        end
        rd_before = rdata_s[u];
        @(posedge clk); #1;
        rd_s[u] = rd; wr_s[u] = wr; a_s[u] = a; d_s[u] = d;
        n_stall = 0; v_cyc = -1; e1 = 1'b0; e2 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (stall_s[u]) n_stall++;
            if (v_s[u] && v_cyc < 0) v_cyc = k;
            if (k == 1) e1 = err_s[u];
            if (k == 2) e2 = err_s[u];
            if (k == 0) begin
                @(posedge clk); #1;
                clear_inputs(u);
            end
        end
        exp_stall = legal ? lat : 0;
        exp_v     = (legal && rd) ? lat : -1;
        checks++;
        if (n_stall != exp_stall) begin
            failures++;
            $display("FAIL stall_cycles u%0d addr=%h got=%0d exp=%0d", u, a, n_stall, exp_stall);
        end
        checks++;
        if (e1 !== !legal) begin
            failures++;
            $display("FAIL err_pulse u%0d addr=%h got=%b exp=%b", u, a, e1, !legal);
        end
        checks++;
        if (e2 !== 1'b0) begin
            failures++;
            $display("FAIL err_width u%0d addr=%h got=%b exp=0", u, a, e2);
        end
        checks++;
        if (v_cyc != exp_v) begin
            failures++;
            $display("FAIL valid_cycle u%0d addr=%h got=%0d exp=%0d", u, a, v_cyc, exp_v);
        end
        if (!legal) begin
            checks++;
            if (rdata_s[u] !== rd_before) begin
                failures++;
                $display("FAIL rdata_held u%0d got=%h exp=%h", u, rdata_s[u], rd_before);
            end
        end
        if (legal && wr) mdl[u][a[9:2]] = d;
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        rd_s[0] = 1'b1; a_s[0] = 32'h0;
        #2;
        checks++;
        if (stall_s[0] !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_stall got=%b exp=1", stall_s[0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({stall_s[0], v_s[0], err_s[0]} !== 3'b000 || rdata_s[0] !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs stall=%b valid=%b err=%b rdata=%h exp 0/0/0/0",
                     stall_s[0], v_s[0], err_s[0], rdata_s[0]);
        end
        clear_inputs(0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_store_load;
        issue(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        issue(0, 1'b1, 1'b0, 32'h10, 32'h0);
    endtask

    task automatic test_misaligned;
        issue(0, 1'b1, 1'b0, 32'h13, 32'h0);
    endtask

    task automatic test_conflict;
        issue(0, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D);
        issue(0, 1'b1, 1'b1, 32'h20, 32'h0BADBEEF);
        issue(0, 1'b1, 1'b0, 32'h20, 32'h0);
    endtask

    task automatic test_alias;
        issue(0, 1'b0, 1'b1, 32'h404, 32'h00001234);
        issue(0, 1'b1, 1'b0, 32'h004, 32'h0);
    endtask

    task automatic test_back_to_back;
        logic [4:0] st, vv;
        issue(1, 1'b0, 1'b1, 32'h0, 32'h11111111);
        issue(1, 1'b0, 1'b1, 32'h4, 32'h22222222);
        sbq1.push_back(mdl[1][0]);
        sbq1.push_back(mdl[1][1]);
        @(posedge clk); #1;
        rd_s[1] = 1'b1; a_s[1] = 32'h0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            st[k] = stall_s[1];
            vv[k] = v_s[1];
            @(posedge clk); #1;
            if (k == 0) a_s[1] = 32'h4;
            if (k == 2) clear_inputs(1);
        end
        checks++;
        if (st !== 5'b00101) begin
            failures++;
            $display("FAIL b2b_stall got=%b exp=00101", st);
        end
        checks++;
        if (vv !== 5'b01010) begin
            failures++;
            $display("FAIL b2b_valid got=%b exp=01010", vv);
        end
    endtask

    task automatic test_reset_busy;
        issue(0, 1'b0, 1'b1, 32'h8, 32'hA5A5A5A5);
        @(posedge clk); #1;
        wr_s[0] = 1'b1; a_s[0] = 32'h8; d_s[0] = 32'h55;
        @(posedge clk); #1;
        clear_inputs(0);
        #2;
        checks++;
        if (stall_s[0] !== 1'b1) begin
            failures++;
            $display("FAIL busy_stall got=%b exp=1", stall_s[0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (stall_s[0] !== 1'b0) begin
            failures++;
            $display("FAIL busy_reset_stall got=%b exp=0", stall_s[0]);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (rdata_s[0] !== 32'h0 || v_s[0] !== 1'b0) begin
            failures++;
            $display("FAIL busy_reset_out rdata=%h valid=%b exp 0/0", rdata_s[0], v_s[0]);
        end
        issue(0, 1'b1, 1'b0, 32'h8, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs(0);
        clear_inputs(1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        test_reset;
        test_store_load;
        test_misaligned;
        test_conflict;
        test_alias;
        test_back_to_back;
        test_reset_busy;

        repeat (4) @(negedge clk);
        checks++;
        if (sbq0.size() != 0 || sbq1.size() != 0) begin
            failures++;
            $display("FAIL sb_drained pending u0=%0d u1=%0d exp 0/0", sbq0.size(), sbq1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout sim_time=%0t limit=200000", $time);
        $fatal(1);
    end

endmodule
